// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding for the multi-channel sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WRITE = 2'b11
  } seq_state_t;

  localparam seq_state_t SEQ_IDLE  = ST_IDLE;
  localparam seq_state_t SEQ_READ  = ST_READ;
  localparam seq_state_t SEQ_WRITE = ST_WRITE;
  localparam seq_state_t SEQ_WAIT  = ST_WAIT;

endpackage

// File: rtl/seq_channel.sv
// rtl/seq_channel.sv - one idle/write/wait/read handshake FSM with dwell counter
// Optional watchdog: SEQ_WATCHDOG_EN
// Ports: clk, rst_n (async active-low), enable, abort, dwell, sm_in
//        -> state, sm_out, cycle_done, err
module seq_channel
  import seq_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int WD_W    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               sm_in,
  output seq_state_t         state,
  output logic               sm_out,
  output logic               cycle_done,
  output logic               err
);

  logic [DWELL_W-1:0] cnt;
  logic               wd_trip;

  assign sm_out = (state == SEQ_READ) || (state == SEQ_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_IDLE;
      cnt        <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      // abort and a watchdog trip both drop to IDLE without a completion pulse
      if (abort || wd_trip) begin
        state <= SEQ_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          SEQ_IDLE:  if (enable && sm_in) state <= SEQ_WRITE;
          SEQ_WRITE: if (!sm_in) begin
                       state <= SEQ_WAIT;
                       cnt   <= dwell;
                     end
          // count down first; exit only once the loaded dwell has fully elapsed
          SEQ_WAIT:  if (cnt != '0) cnt <= cnt - 1'b1;
                     else if (sm_in) state <= SEQ_READ;
          SEQ_READ:  if (!sm_in) begin
                       state      <= SEQ_IDLE;
                       cycle_done <= 1'b1;
                     end
          default:   state <= SEQ_IDLE;
        endcase
      end
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [WD_W-1:0] wd;
  logic            active;
  logic            leave;

  assign active  = (state == SEQ_WRITE) || (state == SEQ_READ);
  assign leave   = ((state == SEQ_IDLE)  && enable && sm_in) ||
                   ((state == SEQ_WRITE) && !sm_in) ||
                   ((state == SEQ_WAIT)  && (cnt == '0) && sm_in) ||
                   ((state == SEQ_READ)  && !sm_in);
  assign wd_trip = active && (&wd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd  <= '0;
      err <= 1'b0;
    end else if (abort) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (wd_trip) err <= 1'b1;
      if (wd_trip || leave || !active) wd <= '0;
      else                             wd <= wd + 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  // no watchdog: err is a constant 0 for every legal width
  assign err     = (WD_W < 0);
`endif

endmodule

// File: rtl/multi_channel_sequencer.sv
// rtl/multi_channel_sequencer.sv - CHANNELS independent droplet handshake FSMs
// Optional watchdog: SEQ_WATCHDOG_EN
// Ports: sm_clock, reset (async active-low), enable, abort, dwell, sm_in
//        -> sm_out, state_out (2 bits per channel), cycle_done, busy, err
module multi_channel_sequencer
  import seq_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL_W  = 8,
  parameter int WD_W     = 12
) (
  input  logic                  sm_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  abort,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [CHANNELS-1:0]   sm_in,
  output logic [CHANNELS-1:0]   sm_out,
  output logic [2*CHANNELS-1:0] state_out,
  output logic [CHANNELS-1:0]   cycle_done,
  output logic                  busy,
  output logic [CHANNELS-1:0]   err
);

  logic [CHANNELS-1:0] active;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    seq_state_t st;

    seq_channel #(
      .DWELL_W (DWELL_W),
      .WD_W    (WD_W)
    ) u_ch (
      .clk        (sm_clock),
      .rst_n      (reset),
      .enable     (enable),
      .abort      (abort),
      .dwell      (dwell),
      .sm_in      (sm_in[c]),
      .state      (st),
      .sm_out     (sm_out[c]),
      .cycle_done (cycle_done[c]),
      .err        (err[c])
    );

    assign state_out[2*c +: 2] = st;
    assign active[c]           = (st != SEQ_IDLE);
  end

  assign busy = |active;

endmodule

// File: tb/tb_multi_channel_sequencer.sv
// tb/tb_multi_channel_sequencer.sv - directed vector bench for multi_channel_sequencer
module tb_multi_channel_sequencer;

  logic       sm_clock;
  logic       reset;
  logic       enable;
  logic       abort;
  logic [7:0] dwell;
  logic [3:0] sm_in;
  logic [3:0] sm_out;
  logic [7:0] state_out;
  logic [3:0] cycle_done;
  logic       busy;
  logic [3:0] err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       ab;
    logic [7:0] dw;
    logic [3:0] in;
    logic [7:0] st;
    logic [3:0] so;
    logic [3:0] cd;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  multi_channel_sequencer #(
    .CHANNELS (4),
    .DWELL_W  (8),
    .WD_W     (12)
  ) dut (
    .sm_clock   (sm_clock),
    .reset      (reset),
    .enable     (enable),
    .abort      (abort),
    .dwell      (dwell),
    .sm_in      (sm_in),
    .sm_out     (sm_out),
    .state_out  (state_out),
    .cycle_done (cycle_done),
    .busy       (busy),
    .err        (err)
  );

  initial sm_clock = 1'b0;
  always #5 sm_clock = ~sm_clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic ab, input logic [7:0] dw, input logic [3:0] in,
                     input logic [7:0] st, input logic [3:0] so, input logic [3:0] cd, input logic bz);
    vec_t v;
    v.en = en; v.ab = ab; v.dw = dw; v.in = in;
    v.st = st; v.so = so; v.cd = cd; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic [3:0] so,
                         input logic [3:0] cd, input logic bz);
    chk({tag, " state_out"},  state_out,  st);
    chk({tag, " sm_out"},     sm_out,     so);
    chk({tag, " cycle_done"}, cycle_done, cd);
    chk({tag, " busy"},       busy,       bz);
    chk({tag, " err"},        err,        4'b0000);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    abort  = 1'b0;
    dwell  = 8'd0;
    sm_in  = 4'b0000;

    // full cycle on ch0 with dwell=3: READ four edges after WAIT entry
    add(1, 0,   3, 4'b0001, 8'b00000011, 4'b0000, 4'b0000, 1);
    add(1, 0,   3, 4'b0000, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   3, 4'b0001, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   3, 4'b0001, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   3, 4'b0001, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   3, 4'b0001, 8'b00000001, 4'b0001, 4'b0000, 1);
    add(1, 0,   3, 4'b0000, 8'b00000000, 4'b0000, 4'b0001, 0);
    add(1, 0,   3, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    // dwell=0: WAIT exits on its first cycle
    add(1, 0,   0, 4'b0001, 8'b00000011, 4'b0000, 4'b0000, 1);
    add(1, 0,   0, 4'b0000, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   0, 4'b0001, 8'b00000001, 4'b0001, 4'b0000, 1);
    add(1, 0,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0001, 0);
    add(1, 0,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    // dwell raised to 200 mid-WAIT: count loaded at entry still governs
    add(1, 0,   3, 4'b0001, 8'b00000011, 4'b0000, 4'b0000, 1);
    add(1, 0,   3, 4'b0000, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0, 200, 4'b0001, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0, 200, 4'b0001, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0, 200, 4'b0001, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0, 200, 4'b0001, 8'b00000001, 4'b0001, 4'b0000, 1);
    add(1, 0, 200, 4'b0000, 8'b00000000, 4'b0000, 4'b0001, 0);
    add(1, 0, 200, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    // enable=0 blocks starts from IDLE
    add(0, 0,   0, 4'b1111, 8'b00000000, 4'b0000, 4'b0000, 0);
    add(0, 0,   0, 4'b1111, 8'b00000000, 4'b0000, 4'b0000, 0);
    // ch2 started, then enable dropped: ch2 completes, others stay IDLE
    add(1, 0,   2, 4'b0100, 8'b00110000, 4'b0000, 4'b0000, 1);
    add(0, 0,   2, 4'b0000, 8'b00100000, 4'b0100, 4'b0000, 1);
    add(0, 0,   2, 4'b1111, 8'b00100000, 4'b0100, 4'b0000, 1);
    add(0, 0,   2, 4'b1111, 8'b00100000, 4'b0100, 4'b0000, 1);
    add(0, 0,   2, 4'b1111, 8'b00010000, 4'b0100, 4'b0000, 1);
    add(0, 0,   2, 4'b1011, 8'b00000000, 4'b0000, 4'b0100, 0);
    add(0, 0,   2, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    // ch0 IDLE, ch1 WRITE, ch2 WAIT, ch3 READ, then one-cycle abort
    add(1, 0,   0, 4'b1100, 8'b11110000, 4'b0000, 4'b0000, 1);
    add(0, 0,   0, 4'b0000, 8'b10100000, 4'b1100, 4'b0000, 1);
    add(0, 0,   0, 4'b1000, 8'b01100000, 4'b1100, 4'b0000, 1);
    add(1, 0,   0, 4'b1010, 8'b01101100, 4'b1100, 4'b0000, 1);
    add(1, 1,   0, 4'b1010, 8'b00000000, 4'b0000, 4'b0000, 0);
    add(0, 0,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    // abort on the READ->IDLE edge: no completion pulse
    add(1, 0,   0, 4'b0001, 8'b00000011, 4'b0000, 4'b0000, 1);
    add(1, 0,   0, 4'b0000, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   0, 4'b0001, 8'b00000001, 4'b0001, 4'b0000, 1);
    add(1, 1,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    add(1, 0,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    // abort while cycle_done is high: pulse still lasts one cycle
    add(1, 0,   0, 4'b0001, 8'b00000011, 4'b0000, 4'b0000, 1);
    add(1, 0,   0, 4'b0000, 8'b00000010, 4'b0001, 4'b0000, 1);
    add(1, 0,   0, 4'b0001, 8'b00000001, 4'b0001, 4'b0000, 1);
    add(1, 0,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0001, 0);
    add(1, 1,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);
    add(0, 0,   0, 4'b0000, 8'b00000000, 4'b0000, 4'b0000, 0);

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge sm_clock);
      enable = 1'($urandom_range(1));
      abort  = 1'($urandom_range(1));
      dwell  = 8'($urandom_range(255));
      sm_in  = 4'($urandom_range(15));
      @(posedge sm_clock);
      #1;
      chk_all($sformatf("reset%0d", i), 8'h00, 4'h0, 4'h0, 1'b0);
    end

    @(negedge sm_clock);
    reset  = 1'b1;
    enable = 1'b1;
    abort  = 1'b0;
    sm_in  = 4'b0000;
    @(posedge sm_clock);
    #1;
    chk_all("release", 8'h00, 4'h0, 4'h0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge sm_clock);
      enable = vecs[i].en;
      abort  = vecs[i].ab;
      dwell  = vecs[i].dw;
      sm_in  = vecs[i].in;
      @(posedge sm_clock);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].so, vecs[i].cd, vecs[i].bz);
    end

    // asynchronous reset in the middle of a WAIT
    @(negedge sm_clock);
    enable = 1'b1;
    abort  = 1'b0;
    dwell  = 8'd0;
    sm_in  = 4'b0001;
    @(posedge sm_clock);
    @(negedge sm_clock);
    sm_in = 4'b0000;
    @(posedge sm_clock);
    #1;
    chk("midrst pre state_out", state_out, 8'b00000010);
    #2;
    reset = 1'b0;
    #1;
    chk_all("midrst async", 8'h00, 4'h0, 4'h0, 1'b0);
    @(negedge sm_clock);
    reset  = 1'b1;
    enable = 1'b0;
    sm_in  = 4'b0001;
    @(posedge sm_clock);
    #1;
    chk_all("midrst after", 8'h00, 4'h0, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
